// File: rtl/mem_pkg.sv
// Shared load/store encodings and the byte-order helper used by the load-return path.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_DISABLE = 2'b00,
    READ_SEXT   = 2'b01,
    READ_ZEXT   = 2'b10,
    WRITE       = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    HALF  = 2'b01,
    WORD  = 2'b10,
    DWORD = 2'b11
  } mem_size_e;

  // Reverses the lowest nbytes bytes of d; bytes above nbytes come back zero.
  function automatic logic [63:0] byte_reverse(input logic [63:0] d, input int nbytes);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < nbytes) r[8*i +: 8] = d[8*(nbytes-1-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_load_align_if.sv
// Request, memory-return and result handshake bundle of the load-return stage.
interface mem_load_align_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  localparam int OFF_W = $clog2(DATA_W/8);

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [1:0]        req_size;
  logic [OFF_W-1:0]  req_off;
  logic [TAG_W-1:0]  req_tag;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_fault;
  logic              err_orphan;

  modport master (
    output req_valid, req_op, req_size, req_off, req_tag, mem_valid, mem_rdata, out_ready,
    input  req_ready, out_valid, out_data, out_tag, out_fault, err_orphan
  );

  modport slave (
    input  req_valid, req_op, req_size, req_off, req_tag, mem_valid, mem_rdata, out_ready,
    output req_ready, out_valid, out_data, out_tag, out_fault, err_orphan
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
    if (push_ok && !pop_ok) cnt_d = cnt_q + 1'b1;
    if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/mem_load_align.sv
// Load-return stage: tracks outstanding loads, aligns and extends returning data,
// and hands results back in request order over a valid/ready port.
module mem_load_align
  import mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 2,
  parameter int TAG_W      = 5,
  parameter int SWAP_BYTES = 1
) (
  input  logic             clk,
  input  logic             reset,
  mem_load_align_if.slave  bus
);
  localparam int OFF_W = $clog2(DATA_W/8);
  localparam int REQ_W = 4 + OFF_W + TAG_W;
  localparam int RES_W = DATA_W + TAG_W + 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] lane,
                                               input logic [1:0] size, input logic sext);
    logic [DATA_W-1:0] mask;
    logic              msb;
    case (mem_size_e'(size))
      BYTE:    begin mask = DATA_W'(8'hFF);        msb = lane[7];        end
      HALF:    begin mask = DATA_W'(16'hFFFF);     msb = lane[15];       end
      WORD:    begin mask = DATA_W'(32'hFFFF_FFFF); msb = lane[31];      end
      default: begin mask = '1;                    msb = lane[DATA_W-1]; end
    endcase
    return (sext && msb) ? (lane | ~mask) : (lane & mask);
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [OFF_W-1:0] off);
    case (mem_size_e'(size))
      HALF:    return off[0];
      WORD:    return (off & OFF_W'(3)) != '0;
      DWORD:   return (DATA_W == 32) || (off != '0);
      default: return 1'b0;
    endcase
  endfunction

  logic [REQ_W-1:0]  req_wdata, req_head;
  logic [RES_W-1:0]  res_wdata, res_head;
  logic [CNT_W-1:0]  req_cnt, res_cnt;
  logic [CNT_W:0]    credits;
  logic              req_full, req_empty, res_empty, res_full_unused;
  logic              ready, is_read, req_push, mem_hit, res_pop;
  logic              orphan_q, orphan_d;
  logic [1:0]        h_op, h_size;
  logic [OFF_W-1:0]  h_off;
  logic [TAG_W-1:0]  h_tag;
  logic [DATA_W-1:0] w, lane, aligned;
  logic              fault;

  // Credit accounting over both FIFOs; counts are registered, so freed credits show next cycle.
  assign credits  = {1'b0, req_cnt} + {1'b0, res_cnt};
  assign ready    = (credits < (CNT_W+1)'(DEPTH)) && !req_full;
  assign is_read  = (bus.req_op == READ_SEXT) || (bus.req_op == READ_ZEXT);
  assign req_push = bus.req_valid && ready && is_read;
  assign req_wdata = {bus.req_op, bus.req_size, bus.req_off, bus.req_tag};

  sync_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_req_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (req_push),
    .pop_i   (mem_hit),
    .wdata_i (req_wdata),
    .rdata_o (req_head),
    .full_o  (req_full),
    .empty_o (req_empty),
    .count_o (req_cnt)
  );

  // Memory return stage: align the raw word against the oldest outstanding request.
  assign mem_hit  = bus.mem_valid && !req_empty;
  assign orphan_d = orphan_q | (bus.mem_valid && req_empty);
  assign {h_op, h_size, h_off, h_tag} = req_head;

  assign w       = (SWAP_BYTES != 0) ? DATA_W'(byte_reverse(64'(bus.mem_rdata), DATA_W/8))
                                     : bus.mem_rdata;
  assign lane    = w >> {h_off, 3'b000};
  assign fault   = misaligned(h_size, h_off);
  assign aligned = fault ? '0 : extend(lane, h_size, h_op == READ_SEXT);
  assign res_wdata = {fault, h_tag, aligned};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) orphan_q <= 1'b0;
    else       orphan_q <= orphan_d;
  end

  // Result stage: registered results drain in order; outputs read zero when nothing is held.
  assign res_pop = !res_empty && bus.out_ready;

  sync_fifo #(.WIDTH(RES_W), .DEPTH(DEPTH)) u_res_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (mem_hit),
    .pop_i   (res_pop),
    .wdata_i (res_wdata),
    .rdata_o (res_head),
    .full_o  (res_full_unused),
    .empty_o (res_empty),
    .count_o (res_cnt)
  );

  assign bus.req_ready  = ready;
  assign bus.out_valid  = !res_empty;
  assign bus.out_data   = res_empty ? '0 : res_head[DATA_W-1:0];
  assign bus.out_tag    = res_empty ? '0 : res_head[DATA_W +: TAG_W];
  assign bus.out_fault  = !res_empty && res_head[RES_W-1];
  assign bus.err_orphan = orphan_q;
endmodule

// File: tb/tb_mem_load_align.sv
// Directed bench for mem_load_align with a queue-level reference model checked every cycle.
module tb_mem_load_align;
  localparam logic [31:0] RAW = 32'h80FF_3412;

  typedef struct {
    logic [1:0] op;
    logic [1:0] size;
    logic [1:0] off;
    logic [4:0] tag;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        fault;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passes = 0;

  mem_load_align_if #(.DATA_W(32), .TAG_W(5)) bif ();

  mem_load_align #(.DATA_W(32), .DEPTH(2), .TAG_W(5), .SWAP_BYTES(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    else passes++;
  endtask

  // Reference: byte-reverse, shift to the addressed byte, keep 8<<size bits, then
  // reinterpret as signed for sign-extending loads.
  function automatic res_t model_load(input logic [31:0] raw, input req_t r);
    res_t        o;
    logic [31:0] w;
    longint      lane, v, span;
    int          nbits;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = raw[8*(3-i) +: 8];
    lane    = longint'(w >> (8 * int'(r.off)));
    nbits   = 8 << r.size;
    o.tag   = r.tag;
    o.fault = (r.size == 2'd1 && r.off[0]) || (r.size == 2'd2 && r.off != 2'd0) || (r.size == 2'd3);
    o.data  = '0;
    if (!o.fault) begin
      span = longint'(1) << nbits;
      v    = lane % span;
      if (r.op == 2'd1 && v >= span / 2) v = v - span;
      o.data = v[31:0];
    end
    return o;
  endfunction

  req_t req_q[$];
  res_t res_q[$];
  bit   orphan_m;

  always @(posedge clk or posedge reset) begin
    int   credits;
    bit   hit;
    res_t r;
    req_t nr;
    if (reset) begin
      req_q.delete();
      res_q.delete();
      orphan_m = 1'b0;
    end else begin
      credits = req_q.size() + res_q.size();
      hit = 1'b0;
      if (bif.mem_valid) begin
        if (req_q.size() == 0) orphan_m = 1'b1;
        else begin
          r   = model_load(bif.mem_rdata, req_q.pop_front());
          hit = 1'b1;
        end
      end
      if (res_q.size() > 0 && bif.out_ready) void'(res_q.pop_front());
      if (hit) res_q.push_back(r);
      if (bif.req_valid && credits < 2 && (bif.req_op == 2'd1 || bif.req_op == 2'd2)) begin
        nr.op = bif.req_op; nr.size = bif.req_size; nr.off = bif.req_off; nr.tag = bif.req_tag;
        req_q.push_back(nr);
      end
    end
  end

  always @(negedge clk) begin
    logic        ev;
    logic [31:0] ed;
    logic [4:0]  et;
    logic        ef;
    ev = (res_q.size() > 0);
    ed = ev ? res_q[0].data : 32'h0;
    et = ev ? res_q[0].tag : 5'h0;
    ef = ev ? res_q[0].fault : 1'b0;
    chk("model out_valid", 64'(bif.out_valid), 64'(ev));
    chk("model out_data", 64'(bif.out_data), 64'(ed));
    chk("model out_tag", 64'(bif.out_tag), 64'(et));
    chk("model out_fault", 64'(bif.out_fault), 64'(ef));
    chk("model req_ready", 64'(bif.req_ready), 64'((req_q.size() + res_q.size()) < 2));
    chk("model err_orphan", 64'(bif.err_orphan), 64'(orphan_m));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] op, input logic [1:0] size, input logic [1:0] off,
                      input logic [4:0] tag, input logic [31:0] exp_d, input logic exp_f,
                      input string nm);
    bif.req_valid = 1'b1; bif.req_op = op; bif.req_size = size; bif.req_off = off; bif.req_tag = tag;
    step();
    bif.req_valid = 1'b0;
    bif.mem_valid = 1'b1; bif.mem_rdata = RAW;
    step();
    bif.mem_valid = 1'b0;
    @(negedge clk);
    chk({nm, " valid"}, 64'(bif.out_valid), 64'd1);
    chk({nm, " data"}, 64'(bif.out_data), 64'(exp_d));
    chk({nm, " tag"}, 64'(bif.out_tag), 64'(tag));
    chk({nm, " fault"}, 64'(bif.out_fault), 64'(exp_f));
    step();
  endtask

  initial begin
    bif.req_valid = 1'b0; bif.req_op = 2'd0; bif.req_size = 2'd0; bif.req_off = 2'd0;
    bif.req_tag = 5'd0; bif.mem_valid = 1'b0; bif.mem_rdata = 32'h0; bif.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("reset out_valid", 64'(bif.out_valid), 64'd0);
    chk("reset out_data", 64'(bif.out_data), 64'd0);
    chk("reset req_ready", 64'(bif.req_ready), 64'd1);
    chk("reset err_orphan", 64'(bif.err_orphan), 64'd0);
    step();
    reset = 1'b0;
    step();

    load(2'd1, 2'd0, 2'd0, 5'd3,  32'hFFFF_FF80, 1'b0, "sext byte off0");
    load(2'd2, 2'd0, 2'd1, 5'd4,  32'h0000_00FF, 1'b0, "zext byte off1");
    load(2'd1, 2'd1, 2'd2, 5'd5,  32'h0000_1234, 1'b0, "sext half off2");
    load(2'd1, 2'd2, 2'd0, 5'd6,  32'h1234_FF80, 1'b0, "sext word off0");
    load(2'd1, 2'd1, 2'd0, 5'd9,  32'hFFFF_FF80, 1'b0, "sext half off0");
    load(2'd2, 2'd1, 2'd0, 5'd10, 32'h0000_FF80, 1'b0, "zext half off0");
    load(2'd1, 2'd0, 2'd3, 5'd11, 32'h0000_0012, 1'b0, "sext byte off3");
    load(2'd1, 2'd1, 2'd1, 5'd12, 32'h0000_0000, 1'b1, "half misaligned");
    load(2'd1, 2'd2, 2'd2, 5'd13, 32'h0000_0000, 1'b1, "word misaligned");
    load(2'd1, 2'd3, 2'd0, 5'd14, 32'h0000_0000, 1'b1, "dword on 32b");

    // Writes and disabled ops consume no credit.
    bif.req_valid = 1'b1; bif.req_op = 2'd3; bif.req_tag = 5'd20; step();
    bif.req_op = 2'd0; step();
    bif.req_valid = 1'b0;
    @(negedge clk);
    chk("write no credit", 64'(bif.req_ready), 64'd1);
    chk("write no result", 64'(bif.out_valid), 64'd0);
    step();

    // Backpressure: two results buffered, pool exhausted, drained in order.
    bif.out_ready = 1'b0;
    bif.req_valid = 1'b1; bif.req_op = 2'd1; bif.req_size = 2'd2; bif.req_off = 2'd0; bif.req_tag = 5'd7;
    step();
    bif.req_op = 2'd2; bif.req_size = 2'd0; bif.req_off = 2'd1; bif.req_tag = 5'd8;
    bif.mem_valid = 1'b1; bif.mem_rdata = RAW;
    step();
    bif.req_valid = 1'b0;
    step();
    bif.mem_valid = 1'b0;
    @(negedge clk);
    chk("full req_ready", 64'(bif.req_ready), 64'd0);
    chk("full head tag", 64'(bif.out_tag), 64'd7);
    chk("full head data", 64'(bif.out_data), 64'h1234_FF80);
    step(); step();
    @(negedge clk);
    chk("stall hold tag", 64'(bif.out_tag), 64'd7);
    chk("stall hold data", 64'(bif.out_data), 64'h1234_FF80);
    step();
    bif.out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("drain second tag", 64'(bif.out_tag), 64'd8);
    chk("drain second data", 64'(bif.out_data), 64'h0000_00FF);
    chk("credit back", 64'(bif.req_ready), 64'd1);
    step();
    @(negedge clk);
    chk("drained", 64'(bif.out_valid), 64'd0);
    step();

    // Orphan response.
    bif.mem_valid = 1'b1; bif.mem_rdata = RAW; step();
    bif.mem_valid = 1'b0;
    @(negedge clk);
    chk("orphan set", 64'(bif.err_orphan), 64'd1);
    chk("orphan no result", 64'(bif.out_valid), 64'd0);
    step(); step();
    @(negedge clk);
    chk("orphan sticky", 64'(bif.err_orphan), 64'd1);
    step();

    // Reset with one buffered result and one load in flight.
    bif.out_ready = 1'b0;
    bif.req_valid = 1'b1; bif.req_op = 2'd1; bif.req_size = 2'd0; bif.req_off = 2'd0; bif.req_tag = 5'd1;
    step();
    bif.req_tag = 5'd2; bif.mem_valid = 1'b1;
    step();
    bif.req_valid = 1'b0; bif.mem_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid reset out_valid", 64'(bif.out_valid), 64'd0);
    chk("mid reset out_data", 64'(bif.out_data), 64'd0);
    chk("mid reset out_tag", 64'(bif.out_tag), 64'd0);
    chk("mid reset req_ready", 64'(bif.req_ready), 64'd1);
    chk("mid reset err_orphan", 64'(bif.err_orphan), 64'd0);
    step();
    reset = 1'b0;
    bif.out_ready = 1'b1;
    step();
    bif.mem_valid = 1'b1; step();
    bif.mem_valid = 1'b0;
    @(negedge clk);
    chk("stray after reset", 64'(bif.err_orphan), 64'd1);
    chk("stray no result", 64'(bif.out_valid), 64'd0);
    step(); step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
